// File: rtl/cim_stream_mac_engine.sv
// cim_stream_mac_engine
// NUM_STACKS lockstep lanes. Each lane forms a signed dot product of NUM_INPUTS
// activations against bit-serial weights (one weight bit per cycle, LSB first),
// accumulates it over a group of vectors, and scales the group result by a value
// taken from a shared scale FIFO. Results leave on a valid/ready stream.
// Optional feature macro: CIM_SATURATE_EN. When it is defined, results are clamped
// to the signed OUT_W range. When it is undefined, the low OUT_W bits are kept.
module cim_stream_mac_engine #(
  parameter int NUM_STACKS  = 8,
  parameter int NUM_INPUTS  = 8,
  parameter int ACT_W       = 8,
  parameter int WT_W        = 4,
  parameter int SCALE_W     = 8,
  parameter int MAX_VECTORS = 16,
  parameter int SCALE_DEPTH = 4,
  parameter int OUT_W       = 24
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [NUM_STACKS*NUM_INPUTS*ACT_W-1:0] s_act,
  input  logic [NUM_STACKS*NUM_INPUTS*WT_W-1:0]  s_wt,
  input  logic [$clog2(MAX_VECTORS):0]          cfg_num_vectors,
  input  logic                                  cfg_scale_bypass,
  input  logic                                  scale_wr_en,
  input  logic [SCALE_W-1:0]                    scale_wr_data,
  output logic                                  scale_full,
  output logic                                  scale_overflow,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [NUM_STACKS*OUT_W-1:0]           m_data,
  output logic                                  busy
);

  localparam int PSUM_W = ACT_W + WT_W + $clog2(NUM_INPUTS);
  localparam int ACC_W  = PSUM_W + $clog2(MAX_VECTORS);
  localparam int PROD_W = ACC_W + SCALE_W;
  localparam int CNT_W  = (WT_W > 1) ? $clog2(WT_W) : 1;
  localparam int VEC_W  = $clog2(MAX_VECTORS) + 1;
  localparam int PTR_W  = (SCALE_DEPTH > 1) ? $clog2(SCALE_DEPTH) : 1;
`ifdef CIM_SATURATE_EN
  // Full-precision product so the clamp sees the true value.
  localparam int EXT_W  = (PROD_W > OUT_W) ? PROD_W : OUT_W;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`else
  // Wrapping only needs the low OUT_W bits, which a truncated multiply gives exactly.
  localparam int EXT_W  = OUT_W;
`endif

  typedef enum logic [1:0] {IDLE, COMPUTE, SCALE, OUT} state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     bit_cnt_q, bit_cnt_d;
  logic [VEC_W-1:0]                     vec_cnt_q, vec_cnt_d;
  logic [VEC_W-1:0]                     grp_len_q, grp_len_d;
  logic                                 bypass_q, bypass_d;
  logic [NUM_STACKS*NUM_INPUTS*ACT_W-1:0] act_q, act_d;
  logic [NUM_STACKS*NUM_INPUTS*WT_W-1:0]  wt_q, wt_d;
  logic [VEC_W-1:0]                     cfg_len;

  logic [SCALE_W-1:0]                   scale_mem [SCALE_DEPTH];
  logic [PTR_W-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]                       count_q, count_d;
  logic                                 overflow_q, overflow_d;
  logic signed [SCALE_W-1:0]            scale_head;

  logic fire_in, last_bit, group_done, fifo_empty, fifo_push, fifo_pop, scale_go, out_fire;

  assign s_ready        = (state_q == IDLE) && !reset;
  assign busy           = (state_q != IDLE);
  assign m_valid        = (state_q == OUT);
  assign fire_in        = s_valid && s_ready;
  assign last_bit       = (state_q == COMPUTE) && (bit_cnt_q == CNT_W'(WT_W-1));
  assign group_done     = (vec_cnt_q == grp_len_q - VEC_W'(1));
  assign fifo_empty     = (count_q == '0);
  assign scale_full     = (count_q == (PTR_W+1)'(SCALE_DEPTH));
  assign scale_overflow = overflow_q;
  assign fifo_push      = scale_wr_en && !scale_full;
  assign fifo_pop       = (state_q == SCALE) && !bypass_q && !fifo_empty;
  assign scale_go       = (state_q == SCALE) && (bypass_q || !fifo_empty);
  assign out_fire       = (state_q == OUT) && m_ready;
  assign scale_head     = scale_mem[rd_ptr_q];

  // Group length: 0 means one vector, anything above MAX_VECTORS is clamped.
  always_comb begin
    cfg_len = cfg_num_vectors;
    if (cfg_num_vectors == '0)
      cfg_len = VEC_W'(1);
    else if (cfg_num_vectors > VEC_W'(MAX_VECTORS))
      cfg_len = VEC_W'(MAX_VECTORS);
  end

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire_in) state_d = COMPUTE;
      COMPUTE: if (last_bit) state_d = group_done ? SCALE : IDLE;
      SCALE:   if (scale_go) state_d = OUT;
      OUT:     if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat capture, bit/vector counters and per-group configuration latch.
  always_comb begin
    act_d     = act_q;
    wt_d      = wt_q;
    bit_cnt_d = bit_cnt_q;
    vec_cnt_d = vec_cnt_q;
    grp_len_d = grp_len_q;
    bypass_d  = bypass_q;
    if (fire_in) begin
      act_d     = s_act;
      wt_d      = s_wt;
      bit_cnt_d = '0;
      if (vec_cnt_q == '0) begin
        grp_len_d = cfg_len;
        bypass_d  = cfg_scale_bypass;
      end
    end
    if (state_q == COMPUTE)
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
    if (last_bit)
      vec_cnt_d = vec_cnt_q + VEC_W'(1);
    if (out_fire)
      vec_cnt_d = '0;
  end

  // Scale FIFO pointer/occupancy update; a push into a full FIFO is dropped and flagged.
  always_comb begin
    wr_ptr_d   = fifo_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = fifo_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q || (scale_wr_en && scale_full);
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and FIFO state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      grp_len_q  <= VEC_W'(1);
      bypass_q   <= 1'b0;
      act_q      <= '0;
      wt_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      grp_len_q  <= grp_len_d;
      bypass_q   <= bypass_d;
      act_q      <= act_d;
      wt_q       <= wt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are logically discarded by the pointer reset.
  always_ff @(posedge clk) begin
    if (fifo_push)
      scale_mem[wr_ptr_q] <= scale_wr_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STACKS; gi++) begin : g_lane
      logic signed [PSUM_W-1:0] psum_q, psum_d;
      logic signed [ACC_W-1:0]  acc_q, acc_d;
      logic signed [PSUM_W-1:0] colsum, shifted, psum_nxt;
      logic signed [EXT_W-1:0]  prod;
      logic [OUT_W-1:0]         res;
      logic [OUT_W-1:0]         mdata_q, mdata_d;

      // Column sum of activations whose current weight bit is set.
      always_comb begin
        colsum = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (wt_q[(gi*NUM_INPUTS+i)*WT_W + int'(bit_cnt_q)])
            colsum = colsum + {{(PSUM_W-ACT_W){act_q[(gi*NUM_INPUTS+i)*ACT_W + ACT_W-1]}},
                               act_q[(gi*NUM_INPUTS+i)*ACT_W +: ACT_W]};
        end
      end

      // Shift-add partial sum; the weight MSB carries negative weight.
      always_comb begin
        shifted  = colsum << bit_cnt_q;
        psum_nxt = (bit_cnt_q == CNT_W'(WT_W-1)) ? psum_q - shifted : psum_q + shifted;
        psum_d   = psum_q;
        if (fire_in)
          psum_d = '0;
        else if (state_q == COMPUTE)
          psum_d = psum_nxt;
      end

      // Group accumulator: add the finished dot product, clear after delivery.
      always_comb begin
        acc_d = acc_q;
        if (last_bit)
          acc_d = acc_q + ACC_W'(psum_nxt);
        else if (out_fire)
          acc_d = '0;
      end

      // Scaling of the group result (identity when bypassed).
      always_comb begin
        prod = bypass_q ? EXT_W'(acc_q) : EXT_W'(acc_q) * EXT_W'(scale_head);
      end

`ifdef CIM_SATURATE_EN
      // Clamp to the signed output range.
      always_comb begin
        if (prod > SAT_MAX)
          res = SAT_MAX[OUT_W-1:0];
        else if (prod < SAT_MIN)
          res = SAT_MIN[OUT_W-1:0];
        else
          res = prod[OUT_W-1:0];
      end
`else
      assign res = prod;
`endif

      // Output register is loaded once on leaving SCALE and held through OUT.
      always_comb begin
        mdata_d = scale_go ? res : mdata_q;
      end

      // Lane state registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          psum_q  <= '0;
          acc_q   <= '0;
          mdata_q <= '0;
        end else begin
          psum_q  <= psum_d;
          acc_q   <= acc_d;
          mdata_q <= mdata_d;
        end
      end

      assign m_data[gi*OUT_W +: OUT_W] = mdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_cim_stream_mac_engine.sv
// Testbench for cim_stream_mac_engine (OUT_W overridden to 16 so narrowing is exercised).
// Honours CIM_SATURATE_EN the same way the design does.
module tb_cim_stream_mac_engine;

  localparam int NS       = 8;
  localparam int NI       = 8;
  localparam int TB_OUT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic [NS*NI*8-1:0]   s_act;
  logic [NS*NI*4-1:0]   s_wt;
  logic [4:0]           cfg_num_vectors;
  logic                 cfg_scale_bypass;
  logic                 scale_wr_en;
  logic [7:0]           scale_wr_data;
  logic                 scale_full;
  logic                 scale_overflow;
  logic                 m_valid;
  logic                 m_ready;
  logic [NS*TB_OUT_W-1:0] m_data;
  logic                 busy;

  cim_stream_mac_engine #(.OUT_W(TB_OUT_W)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_wt(s_wt),
    .cfg_num_vectors(cfg_num_vectors), .cfg_scale_bypass(cfg_scale_bypass),
    .scale_wr_en(scale_wr_en), .scale_wr_data(scale_wr_data),
    .scale_full(scale_full), .scale_overflow(scale_overflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     act_a [NS][NI];
  int     wt_a  [NS][NI];
  longint acc_m [NS];
  longint exp_lane [NS];

  typedef struct {
    int     act;
    int     wt;
    int     nv;
    bit     byp;
    int     scale;
    longint exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic longint lane_val(input int l);
    logic signed [TB_OUT_W-1:0] t;
    t = m_data[l*TB_OUT_W +: TB_OUT_W];
    return longint'(t);
  endfunction

  // Signed narrowing of a result to TB_OUT_W bits.
  function automatic longint narrow(input longint p);
    longint lim;
    longint m;
    lim = longint'(1) <<< (TB_OUT_W-1);
`ifdef CIM_SATURATE_EN
    m = p;
    if (p > lim - 1) m = lim - 1;
    if (p < -lim) m = -lim;
`else
    m = p & (2*lim - 1);
    if (m >= lim) m = m - 2*lim;
`endif
    return m;
  endfunction

  task automatic drive_arrays();
    for (int l = 0; l < NS; l++)
      for (int i = 0; i < NI; i++) begin
        s_act[(l*NI+i)*8 +: 8] = 8'(act_a[l][i]);
        s_wt[(l*NI+i)*4 +: 4]  = 4'(wt_a[l][i]);
      end
  endtask

  task automatic fill_uniform(input int a, input int w);
    for (int l = 0; l < NS; l++)
      for (int i = 0; i < NI; i++) begin
        act_a[l][i] = a;
        wt_a[l][i]  = w;
      end
    drive_arrays();
  endtask

  task automatic fill_random();
    for (int l = 0; l < NS; l++)
      for (int i = 0; i < NI; i++) begin
        act_a[l][i] = int'($urandom_range(0, 255)) - 128;
        wt_a[l][i]  = int'($urandom_range(0, 15)) - 8;
      end
    drive_arrays();
  endtask

  // Adds the current beat's dot products into the model accumulators.
  task automatic model_beat();
    for (int l = 0; l < NS; l++)
      for (int i = 0; i < NI; i++)
        acc_m[l] += longint'(act_a[l][i]) * longint'(wt_a[l][i]);
  endtask

  // Entered and left on a falling edge; returns in the cycle after the handshake.
  task automatic send_beat();
    int n;
    n = 0;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", s_ready, 1);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic push_scale(input int v);
    scale_wr_en   = 1'b1;
    scale_wr_data = 8'(v);
    @(negedge clk);
    scale_wr_en   = 1'b0;
  endtask

  // Waits for a result, holds it for 'hold' cycles under backpressure, compares, accepts.
  task automatic get_result(input string name, input int hold);
    int n;
    logic [NS*TB_OUT_W-1:0] snap;
    n = 0;
    while (!m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, m_valid, 1);
    if (!m_valid) return;
    snap = m_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, m_valid, 1);
      chk({name, "_hold_stable"}, longint'(m_data == snap), 1);
    end
    for (int l = 0; l < NS; l++)
      chk($sformatf("%s_lane%0d", name, l), lane_val(l), exp_lane[l]);
    $display("[%0t] result %s lane0=%0d expected=%0d", $time, name, lane_val(0), exp_lane[0]);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  // Runs one accumulation group; expected values from table (has_exp) or from the model.
  task automatic run_group(input string name, input int nv, input bit byp, input int scale,
                           input bit do_push, input bit rnd, input int a, input int w,
                           input bit has_exp, input longint texp, input int hold);
    int eff;
    eff = (nv == 0) ? 1 : (nv > 16) ? 16 : nv;
    for (int l = 0; l < NS; l++) acc_m[l] = 0;
    if (!byp && do_push) push_scale(scale);
    cfg_num_vectors  = 5'(nv);
    cfg_scale_bypass = byp;
    for (int v = 0; v < eff; v++) begin
      if (rnd) fill_random(); else fill_uniform(a, w);
      model_beat();
      send_beat();
      // Configuration must be ignored after the first beat of the group.
      cfg_num_vectors  = 5'($urandom_range(0, 31));
      cfg_scale_bypass = 1'($urandom_range(0, 1));
    end
    for (int l = 0; l < NS; l++)
      exp_lane[l] = has_exp ? texp : narrow(byp ? acc_m[l] : acc_m[l] * longint'(scale));
    get_result(name, hold);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_act = '0; s_wt = '0;
    cfg_num_vectors = 5'd1; cfg_scale_bypass = 1'b1; scale_wr_en = 1'b0; scale_wr_data = '0;

    tbl[0] = '{act: 1,    wt: 1,  nv: 1,  byp: 1'b1, scale: 0,   exp: 8};
    tbl[1] = '{act: 3,    wt: -1, nv: 1,  byp: 1'b0, scale: 2,   exp: -48};
    tbl[2] = '{act: 1,    wt: 2,  nv: 4,  byp: 1'b1, scale: 0,   exp: 64};
`ifdef CIM_SATURATE_EN
    tbl[3] = '{act: 127,  wt: -8, nv: 1,  byp: 1'b0, scale: 127, exp: -32768};
    tbl[4] = '{act: -128, wt: -8, nv: 16, byp: 1'b1, scale: 0,   exp: 32767};
`else
    tbl[3] = '{act: 127,  wt: -8, nv: 1,  byp: 1'b0, scale: 127, exp: 16320};
    tbl[4] = '{act: -128, wt: -8, nv: 16, byp: 1'b1, scale: 0,   exp: 0};
`endif
    tbl[5] = '{act: -5,   wt: 7,  nv: 0,  byp: 1'b1, scale: 0,   exp: -280};
    tbl[6] = '{act: 2,    wt: 3,  nv: 20, byp: 1'b1, scale: 0,   exp: 768};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_s_ready_during", s_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", longint'(|m_data), 0);
    chk("rst_busy", busy, 0);
    chk("rst_scale_full", scale_full, 0);
    chk("rst_scale_overflow", scale_overflow, 0);

    // Latency and backpressure on a single bypassed vector
    fill_uniform(1, 1);
    cfg_num_vectors = 5'd1; cfg_scale_bypass = 1'b1;
    send_beat();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("lat_busy_T%0d", k), busy, 1);
      chk($sformatf("lat_m_valid_T%0d", k), m_valid, 0);
      chk($sformatf("lat_s_ready_T%0d", k), s_ready, 0);
      @(negedge clk);
    end
    for (int h = 0; h < 5; h++) begin
      chk("bp_m_valid", m_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_s_ready", s_ready, 0);
      for (int l = 0; l < NS; l++) chk($sformatf("bp_lane%0d", l), lane_val(l), 8);
      @(negedge clk);
    end
    chk("bp_m_valid_last", m_valid, 1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_after_m_valid", m_valid, 0);
    chk("bp_after_busy", busy, 0);
    chk("bp_after_s_ready", s_ready, 1);
    $display("[%0t] result latency_backpressure done", $time);

    // Stall in SCALE released by a late push
    fill_uniform(1, 1);
    cfg_num_vectors = 5'd1; cfg_scale_bypass = 1'b0;
    send_beat();
    for (int k = 1; k <= 8; k++) begin
      chk("stall_m_valid", m_valid, 0);
      @(negedge clk);
    end
    chk("stall_busy", busy, 1);
    scale_wr_en = 1'b1; scale_wr_data = 8'd3;
    @(negedge clk);
    scale_wr_en = 1'b0;
    chk("stall_W1_m_valid", m_valid, 0);
    @(negedge clk);
    chk("stall_W2_m_valid", m_valid, 1);
    for (int l = 0; l < NS; l++) exp_lane[l] = 24;
    get_result("stall", 0);

    // FIFO fill and overflow: fifth push is dropped
    for (int j = 0; j < 5; j++) begin
      scale_wr_en = 1'b1; scale_wr_data = 8'(11 + j);
      @(negedge clk);
      if (j == 3) begin
        chk("fifo_full_at4", scale_full, 1);
        chk("fifo_ovf_at4", scale_overflow, 0);
      end
    end
    scale_wr_en = 1'b0;
    chk("fifo_full", scale_full, 1);
    chk("fifo_overflow", scale_overflow, 1);
    for (int j = 0; j < 4; j++) begin
      run_group($sformatf("fifo_pop%0d", j), 1, 1'b0, 11 + j, 1'b0, 1'b0, 1, 1, 1'b0, 0, 0);
      chk("fifo_not_full", scale_full, 0);
    end
    chk("fifo_overflow_sticky", scale_overflow, 1);
    fill_uniform(1, 1);
    cfg_num_vectors = 5'd1; cfg_scale_bypass = 1'b0;
    send_beat();
    repeat (12) @(negedge clk);
    chk("fifo_fifth_dropped", m_valid, 0);
    push_scale(2);
    for (int l = 0; l < NS; l++) exp_lane[l] = 16;
    get_result("fifo_after_drop", 0);

    // Reset in the middle of a partial group with a full FIFO
    for (int j = 0; j < 4; j++) push_scale(7);
    chk("prerst_full", scale_full, 1);
    fill_uniform(2, 2);
    cfg_num_vectors = 5'd4; cfg_scale_bypass = 1'b1;
    send_beat();
    send_beat();
    @(negedge clk);
    chk("prerst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", longint'(|m_data), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_scale_full", scale_full, 0);
    chk("midrst_scale_overflow", scale_overflow, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_s_ready", s_ready, 1);
    run_group("postrst_bypass", 1, 1'b1, 0, 1'b0, 1'b0, 1, 1, 1'b1, 8, 0);
    run_group("postrst_scaled", 1, 1'b0, 5, 1'b1, 1'b0, 1, 1, 1'b1, 40, 0);

    // Table-driven vectors
    for (int t = 0; t < 7; t++)
      run_group($sformatf("tbl%0d", t), tbl[t].nv, tbl[t].byp, tbl[t].scale, 1'b1, 1'b0,
                tbl[t].act, tbl[t].wt, 1'b1, tbl[t].exp, t % 3);

    // Randomized groups against the arithmetic model
    for (int r = 0; r < 30; r++)
      run_group($sformatf("rnd%0d", r), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)) - 128, 1'b1, 1'b1, 0, 0, 1'b0, 0,
                int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
